// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and default sizes for pc_sequencer.
package pc_seq_pkg;
    typedef enum logic [1:0] {RUN, DRAIN, HALT} state_e;
    localparam int DRAIN_CYCLES_DEF = 3;
    localparam int CNT_W_DEF        = 16;
    localparam int DCNT_W           = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at all-ones instead of wrapping.
// Ports: clk, rst_n (async active-low), inc (count this cycle),
//        clear (sync zero, wins over inc), cnt (current value).
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clear,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                  cnt_q <= '0;
        else if (clear)              cnt_q <= '0;
        else if (inc && ~&cnt_q)     cnt_q <= cnt_q + 1'b1;
    end
    assign cnt = cnt_q;
endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: fetch-side PC control (branch/jump redirect, stall, halt drain).
// Ports: clk, rst_n (async active-low); inputs stall_req, br_taken, br_target,
//        jmp_req, jmp_target, hlt_dec; combinational outputs pc_hlt, pc_alt_ctrl,
//        pc_alt, flush_if_id, flush_id_ex; registered output halted.
// Option: define PC_SEQ_PERF_EN to add saturating stall_cnt / redir_cnt outputs.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             stall_req,
    input  logic             br_taken,
    input  logic [15:0]      br_target,
    input  logic             jmp_req,
    input  logic [15:0]      jmp_target,
    input  logic             hlt_dec,
    output logic             pc_hlt,
    output logic             pc_alt_ctrl,
    output logic [15:0]      pc_alt,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             halted
`ifdef PC_SEQ_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redir_cnt
`endif
);
    state_e              state_q, state_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;
    logic                halted_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= RUN;
            dcnt_q   <= '0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            dcnt_q   <= dcnt_d;
            halted_q <= (state_d == HALT);
        end
    end

    always_comb begin
        state_d     = state_q;
        dcnt_d      = dcnt_q;
        pc_hlt      = 1'b0;
        pc_alt_ctrl = 1'b0;
        pc_alt      = 16'h0000;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        case (state_q)
            RUN: begin
                if (br_taken) begin
                    pc_alt_ctrl = 1'b1;
                    pc_alt      = br_target;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (stall_req) begin
                    pc_hlt = 1'b1;
                end else if (hlt_dec) begin
                    pc_hlt      = 1'b1;
                    flush_if_id = 1'b1;
                    state_d     = DRAIN;
                    dcnt_d      = DCNT_W'(DRAIN_CYCLES - 1);
                end else if (jmp_req) begin
                    pc_alt_ctrl = 1'b1;
                    pc_alt      = jmp_target;
                    flush_if_id = 1'b1;
                end
            end
            DRAIN: begin
                // A taken branch means the halt was on a wrong path: abandon the drain.
                if (br_taken) begin
                    pc_alt_ctrl = 1'b1;
                    pc_alt      = br_target;
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    state_d     = RUN;
                    dcnt_d      = '0;
                end else begin
                    pc_hlt      = 1'b1;
                    flush_if_id = 1'b1;
                    if (dcnt_q == '0) state_d = HALT;
                    else              dcnt_d  = dcnt_q - 1'b1;
                end
            end
            HALT: begin
                pc_hlt      = 1'b1;
                flush_if_id = 1'b1;
            end
            default: state_d = RUN;
        endcase
    end

    assign halted = halted_q;

`ifdef PC_SEQ_PERF_EN
    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_hlt && state_q == RUN),
        .clear (1'b0),
        .cnt   (stall_cnt)
    );
    sat_counter #(.W(CNT_W)) u_redir_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (pc_alt_ctrl),
        .clear (1'b0),
        .cnt   (redir_cnt)
    );
`endif
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer (DRAIN_CYCLES=3, CNT_W=4).
module tb_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall_req, br_taken, jmp_req, hlt_dec;
    logic [15:0] br_target, jmp_target;
    logic        pc_hlt, pc_alt_ctrl, flush_if_id, flush_id_ex, halted;
    logic [15:0] pc_alt;
`ifdef PC_SEQ_PERF_EN
    logic [3:0]  stall_cnt, redir_cnt;
`endif
    int          n_chk = 0;
    int          n_pass = 0;

    always #5 clk = ~clk;

    pc_sequencer #(.DRAIN_CYCLES(3), .CNT_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall_req   (stall_req),
        .br_taken    (br_taken),
        .br_target   (br_target),
        .jmp_req     (jmp_req),
        .jmp_target  (jmp_target),
        .hlt_dec     (hlt_dec),
        .pc_hlt      (pc_hlt),
        .pc_alt_ctrl (pc_alt_ctrl),
        .pc_alt      (pc_alt),
        .flush_if_id (flush_if_id),
        .flush_id_ex (flush_id_ex),
        .halted      (halted)
`ifdef PC_SEQ_PERF_EN
        ,
        .stall_cnt   (stall_cnt),
        .redir_cnt   (redir_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One cycle: wait past the rising edge so inputs change away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall_req = 0; br_taken = 0; jmp_req = 0; hlt_dec = 0;
        br_target = '0; jmp_target = '0;
    endtask

    // Packed view of the single-bit outputs: {pc_hlt, pc_alt_ctrl, flush_if_id, flush_id_ex, halted}
    function automatic logic [31:0] flags();
        return {27'd0, pc_hlt, pc_alt_ctrl, flush_if_id, flush_id_ex, halted};
    endfunction

    initial begin
        idle_inputs();
        rst_n = 0;
        repeat (3) step();
        chk("reset_halted", {31'd0, halted}, 0);
        rst_n = 1;
        repeat (5) step();
        #1;
        chk("idle_flags", flags(), 5'b00000);
        chk("idle_alt", pc_alt, 16'h0000);

        // Branch beats a simultaneous stall.
        stall_req = 1; br_taken = 1; br_target = 16'h0040;
        #1;
        chk("br_stall_flags", flags(), 5'b01110);
        chk("br_stall_alt", pc_alt, 16'h0040);
        step();
        idle_inputs();

        // Jump hidden by a stall, then served once the stall drops.
        stall_req = 1; jmp_req = 1; jmp_target = 16'h0123;
        #1;
        chk("jmp_stall_flags", flags(), 5'b10000);
        chk("jmp_stall_alt", pc_alt, 16'h0000);
        step();
        stall_req = 0;
        #1;
        chk("jmp_flags", flags(), 5'b01100);
        chk("jmp_alt", pc_alt, 16'h0123);
        step();
        idle_inputs();

        // Halt beats a jump; drains three cycles, then halts for good.
        hlt_dec = 1; jmp_req = 1; jmp_target = 16'h0555;
        #1;
        chk("hlt_flags", flags(), 5'b10100);
        step();
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            #1;
            chk($sformatf("drain%0d_flags", i), flags(), 5'b10100);
            step();
        end
        chk("halt_enter", {31'd0, halted}, 1);
        for (int i = 0; i < 20; i++) begin
            br_taken = i[0]; br_target = 16'h0777; jmp_req = i[1]; stall_req = i[2];
            jmp_target = 16'h0999;
            #1;
            if (i % 5 == 0) chk($sformatf("halt_hold%0d", i), flags(), 5'b10101);
            if (i == 19) chk("halt_alt", pc_alt, 16'h0000);
            step();
        end
        idle_inputs();
        rst_n = 0;
        #1;
        chk("halt_async_rst", {31'd0, halted}, 0);
        step();
        rst_n = 1;
        step();

        // Branch on the last drain cycle cancels the halt.
        hlt_dec = 1;
        step();
        hlt_dec = 0;
        step();
        step();
        br_taken = 1; br_target = 16'h0010;
        #1;
        chk("drain_br_flags", flags(), 5'b01110);
        chk("drain_br_alt", pc_alt, 16'h0010);
        step();
        idle_inputs();
        #1;
        chk("drain_br_run", flags(), 5'b00000);
        repeat (5) step();
        chk("drain_br_nohalt", {31'd0, halted}, 0);

`ifdef PC_SEQ_PERF_EN
        stall_req = 1;
        repeat (20) step();
        stall_req = 0;
        chk("stall_cnt_sat", {28'd0, stall_cnt}, 4'hF);
`endif

        // Asynchronous reset in the middle of a drain returns to RUN.
        hlt_dec = 1;
        step();
        hlt_dec = 0;
        step();
        rst_n = 0;
        #1;
        chk("mid_drain_rst_flags", flags(), 5'b00000);
`ifdef PC_SEQ_PERF_EN
        chk("mid_drain_rst_stall", {28'd0, stall_cnt}, 0);
        chk("mid_drain_rst_redir", {28'd0, redir_cnt}, 0);
`endif
        step();
        rst_n = 1;
        repeat (6) step();
        chk("mid_drain_rst_nohalt", flags(), 5'b00000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 3, meaning cycles fetch stays frozen after a halt before halted asserts (range 1..15).
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning perf counter width.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, with all state on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-005 The block SHALL have port stall_req, input, 1 bit: load-use hazard; freeze fetch this cycle.
REQ-006 The block SHALL have port br_taken, input, 1 bit: EX-stage branch resolved taken.
REQ-007 The block SHALL have port br_target, input, 16 bits: EX-stage branch destination.
REQ-008 The block SHALL have port jmp_req, input, 1 bit: ID-stage unconditional jump.
REQ-009 The block SHALL have port jmp_target, input, 16 bits: jump destination.
REQ-010 The block SHALL have port hlt_dec, input, 1 bit: halt instruction decoded in ID.
REQ-011 The block SHALL have port pc_hlt, output, 1 bit: drives the program counter's hold input.
REQ-012 The block SHALL have port pc_alt_ctrl, output, 1 bit: selects alt_pc as the next fetch address.
REQ-013 The block SHALL have port pc_alt, output, 16 bits: alternate next fetch address.
REQ-014 The block SHALL have port flush_if_id, output, 1 bit: squash the IF/ID register contents.
REQ-015 The block SHALL have port flush_id_ex, output, 1 bit: squash the ID/EX register contents.
REQ-016 The block SHALL have port halted, output, 1 bit, registered: processor fully halted.
REQ-017 When the perf option is enabled, the block SHALL have port stall_cnt, output, CNT_W bits, and port redir_cnt, output, CNT_W bits.

Function
REQ-018 The FSM SHALL have three states: RUN, DRAIN, HALT.
REQ-019 All control outputs except halted SHALL be combinational from state and inputs, with zero-cycle latency; the program counter registers the choice on the next edge.
REQ-020 In RUN, one event SHALL be served per cycle, in this priority order: br_taken > stall_req > hlt_dec > jmp_req.
REQ-021 On br_taken in RUN: pc_alt_ctrl=1, pc_alt=br_target, flush_if_id=1, flush_id_ex=1, and pc_hlt=0, even when stall_req is also asserted.
REQ-022 On stall_req without br_taken: pc_hlt=1, no flush, and jmp_req and hlt_dec SHALL be ignored that cycle (they re-present after the stall).
REQ-023 On hlt_dec: pc_hlt=1, flush_if_id=1, next state DRAIN, and the drain counter loads DRAIN_CYCLES-1.
REQ-024 On jmp_req: pc_alt_ctrl=1, pc_alt=jmp_target, flush_if_id=1, flush_id_ex=0.
REQ-025 When pc_alt_ctrl=0, pc_alt SHALL be 16'h0000.
REQ-026 In DRAIN: pc_hlt=1, flush_if_id=1, and the counter decrements each cycle; at count 0 the next state SHALL be HALT.
REQ-027 In DRAIN, br_taken SHALL cancel the halt as speculative: redirect per REQ-021 and return to RUN the same edge, including when br_taken arrives on the final drain cycle.
REQ-028 In HALT: halted=1, pc_hlt=1, flush_if_id=1, all other inputs ignored; HALT SHALL be left only by reset.
REQ-029 The halted output SHALL assert on the edge entering HALT.

Reset
REQ-030 Assertion of rst_n low SHALL immediately force state=RUN, drain counter=0, halted=0, and perf counters=0, including mid-DRAIN.
REQ-031 With all inputs low after reset, every combinational output SHALL be 0.

Configuration
REQ-032 With macro PC_SEQ_PERF_EN defined, stall_cnt SHALL count cycles with pc_hlt=1 in RUN, and redir_cnt SHALL count cycles with pc_alt_ctrl=1.
REQ-033 Each perf counter SHALL saturate at all-ones and never wrap.
REQ-034 Without PC_SEQ_PERF_EN, the perf ports and counters SHALL be absent and all other behaviour SHALL be identical.

Structure
REQ-035 Package pc_seq_pkg SHALL hold the state enum (RUN/DRAIN/HALT), the default DRAIN_CYCLES constant, and the counter width constant.
REQ-036 Sub-module sat_counter (parameterised width, with inc, clear, and async rst_n) SHALL implement each perf counter.

Verification
REQ-037 The bench SHALL cover: reset, then idle 5 cycles -> all outputs 0 and halted=0.
REQ-038 The bench SHALL cover: stall_req=1 and br_taken=1 with br_target=16'h0040 -> pc_alt_ctrl=1, pc_alt=16'h0040, both flushes=1, pc_hlt=0.
REQ-039 The bench SHALL cover: jmp_req=1 with jmp_target=16'h0123 during stall_req=1 -> pc_hlt=1, pc_alt_ctrl=0; stall drops next cycle -> pc_alt=16'h0123, flush_if_id=1.
REQ-040 The bench SHALL cover: hlt_dec pulse -> pc_hlt=1 for 3 cycles, then halted=1 on the 4th edge and held for 20 cycles regardless of inputs.
REQ-041 The bench SHALL cover: hlt_dec followed by br_taken on the 3rd DRAIN cycle with target 16'h0010 -> redirect to 16'h0010, back in RUN, halted stays 0.
REQ-042 The bench SHALL cover, with PC_SEQ_PERF_EN and CNT_W=4: 20 stall cycles -> stall_cnt=4'hF; mid-DRAIN rst_n pulse -> state RUN, counters 0.
